vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v position counters, phase FSMs and decoded sync/de/eol/eof.
// Optional VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt_o).
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic          eol_o,
  output logic          eof_o,
  output logic [HW-1:0] h_pos_o,
  output logic [VW-1:0] v_pos_o
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt_o
`endif
);

  if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("vga_timing_gen: every timing parameter must be >= 1");
  end

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FRONT_S = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_S  = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] H_BACK_S  = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FRONT_S = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_S  = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] V_BACK_S  = VW'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic [1:0] {HP_ACTIVE, HP_FRONT, HP_SYNC, HP_BACK} h_phase_t;
  typedef enum logic [1:0] {VP_ACTIVE, VP_FRONT, VP_SYNC, VP_BACK} v_phase_t;

  h_phase_t      h_phase;
  v_phase_t      v_phase;
  logic [HW-1:0] h_pos;
  logic [VW-1:0] v_pos;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_wrap;

  assign h_wrap = (h_pos == H_LAST);
  assign h_nxt  = h_wrap ? '0 : h_pos + 1'b1;
  assign v_nxt  = (v_pos == V_LAST) ? '0 : v_pos + 1'b1;

  // Phases follow the position the counters are about to take, so both stay in lockstep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_pos   <= H_LAST;
      v_pos   <= V_LAST;
      h_phase <= HP_BACK;
      v_phase <= VP_BACK;
    end else if (enable_i) begin
      h_pos <= h_nxt;
      if (h_nxt == H_FRONT_S)     h_phase <= HP_FRONT;
      else if (h_nxt == H_SYNC_S) h_phase <= HP_SYNC;
      else if (h_nxt == H_BACK_S) h_phase <= HP_BACK;
      else if (h_wrap)            h_phase <= HP_ACTIVE;
      if (h_wrap) begin
        v_pos <= v_nxt;
        if (v_nxt == V_FRONT_S)     v_phase <= VP_FRONT;
        else if (v_nxt == V_SYNC_S) v_phase <= VP_SYNC;
        else if (v_nxt == V_BACK_S) v_phase <= VP_BACK;
        else if (v_pos == V_LAST)   v_phase <= VP_ACTIVE;
      end
    end
  end

  assign de_o    = (h_phase == HP_ACTIVE) && (v_phase == VP_ACTIVE);
  assign hsync_o = (h_phase == HP_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
  assign vsync_o = (v_phase == VP_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
  assign eol_o   = h_wrap;
  assign eof_o   = h_wrap && (v_pos == V_LAST);
  assign h_pos_o = h_pos;
  assign v_pos_o = v_pos;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)                  frame_cnt <= '0;
    else if (enable_i && eof_o) frame_cnt <= frame_cnt + 8'd1;
  end

  assign frame_cnt_o = frame_cnt;
`endif

endmodule
